// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: blank codes and the hex-to-segment table.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Purely combinational hex nibble to active-low seven-segment decode.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed 4-digit seven-segment scanner with per-frame shadow capture.
// Optional leading-zero blanking is enabled by defining SEG7_ZERO_BLANK_EN.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        mainClock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  digitEnable,
  input  logic [3:0]  dpIn,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        dpOut,
  output logic        frameDone
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   sh_val_q, sh_val_d;
  logic [3:0]    sh_en_q, sh_en_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;
  logic          tick;
  logic          lit;
  logic [3:0]    nib;
  logic [6:0]    nib_seg;

  // Prescaler, slot index and frame shadow.
  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    sh_val_d = sh_val_q;
    sh_en_d  = sh_en_q;
    sh_dp_d  = sh_dp_q;
    fd_d     = 1'b0;
    if (tick && (idx_q == 2'd3)) begin
      sh_val_d = value;
      sh_en_d  = digitEnable;
      sh_dp_d  = dpIn;
      fd_d     = 1'b1;
    end
  end

  // Outputs look ahead to the next index and shadow so they land together with the advance.
  assign nib = sh_val_d[{idx_d, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble(nib),
    .seg   (nib_seg)
  );

  always_comb begin
    lit = sh_en_d[idx_d];
`ifdef SEG7_ZERO_BLANK_EN
    if ((idx_d != 2'd0) && ((sh_val_d >> {idx_d, 2'b00}) == 16'h0000)) lit = 1'b0;
`endif
    anode_d = anode_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    if (tick) begin
      if (lit) begin
        anode_d = ~(4'b0001 << idx_d);
        seg_d   = nib_seg;
        dp_d    = ~sh_dp_d[idx_d];
      end else begin
        anode_d = ANODE_OFF;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge mainClock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= 2'd3;
      sh_val_q <= '0;
      sh_en_q  <= '0;
      sh_dp_q  <= '0;
      anode_q  <= ANODE_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_en_q  <= sh_en_d;
      sh_dp_q  <= sh_dp_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  assign anode     = anode_q;
  assign segment   = seg_q;
  assign dpOut     = dp_q;
  assign frameDone = fd_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Bench for seg7_scanner: REFRESH_DIV=4 and REFRESH_DIV=1 instances share stimulus.
`timescale 1ns/1ps
module tb_seg7_scanner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] value    = 16'h0000;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_in    = 4'h0;
  logic [3:0]  an4, an1;
  logic [6:0]  sg4, sg1;
  logic        dp4, dp1, fd4, fd1;

  seg7_scanner #(.REFRESH_DIV(4)) u_dut4 (
    .mainClock(clk), .reset(rst), .value(value), .digitEnable(digit_en), .dpIn(dp_in),
    .anode(an4), .segment(sg4), .dpOut(dp4), .frameDone(fd4)
  );

  seg7_scanner #(.REFRESH_DIV(1)) u_dut1 (
    .mainClock(clk), .reset(rst), .value(value), .digitEnable(digit_en), .dpIn(dp_in),
    .anode(an1), .segment(sg1), .dpOut(dp1), .frameDone(fd1)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          div_m  [2] = '{4, 1};
  int          edges  [2];
  int          shown  [2];
  logic [15:0] fr_val [2];
  logic [3:0]  fr_en  [2];
  logic [3:0]  fr_dp  [2];
  logic        exp_fd [2];

  // Edge n after release is a slot boundary when n is a multiple of the divider;
  // the k-th boundary shows digit (k-1) mod 4, and digit 0 starts a new frame.
  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        edges[m]  = 0;
        shown[m]  = -1;
        fr_val[m] = '0;
        fr_en[m]  = '0;
        fr_dp[m]  = '0;
        exp_fd[m] = 1'b0;
      end else begin
        edges[m]++;
        exp_fd[m] = 1'b0;
        if (edges[m] % div_m[m] == 0) begin
          shown[m] = (edges[m] / div_m[m] - 1) % 4;
          if (shown[m] == 0) begin
            fr_val[m] = value;
            fr_en[m]  = digit_en;
            fr_dp[m]  = dp_in;
            exp_fd[m] = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [11:0] model_out(input int m);
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic       on;
    int         d;
    an = 4'hF;
    sg = 7'h7F;
    dp = 1'b1;
    if (shown[m] >= 0) begin
      d  = shown[m];
      on = fr_en[m][d];
`ifdef SEG7_ZERO_BLANK_EN
      if (d > 0 && (fr_val[m] >> (4 * d)) == 16'h0000) on = 1'b0;
`endif
      if (on) begin
        an = ~(4'b0001 << d);
        sg = hex_tab[fr_val[m][4*d +: 4]];
        dp = ~fr_dp[m][d];
      end
    end
    return {an, sg, dp};
  endfunction

  // ---------------- scoreboard: every cycle, both instances ----------------
  always @(negedge clk) begin
    if (checking) begin
      check("scan_div4", 32'({an4, sg4, dp4, fd4}), 32'({model_out(0), exp_fd[0]}));
      check("scan_div1", 32'({an1, sg1, dp1, fd1}), 32'({model_out(1), exp_fd[1]}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frame();
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (!exp_fd[0] && i < 40);
    if (!exp_fd[0]) check("wait_frame_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_slot(input int s);
    for (int i = 0; i < 40 && shown[0] != s; i++) step();
    if (shown[0] != s) check("wait_slot_timeout", 32'(shown[0]), 32'(s));
  endtask

  task automatic wait_dut_fd(input bit use_div1, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!(use_div1 ? fd1 : fd4) && cycles < 40);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] val;
    logic [3:0]  en;
    logic [3:0]  dp;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  sg;
    logic        dpo;
  } vec_t;

  vec_t tab [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int cyc;

    tab.push_back('{16'h1234, 4'hF, 4'h0, 0, 4'b1110, 7'b0011001, 1'b1});
    tab.push_back('{16'h1234, 4'hF, 4'h0, 1, 4'b1101, 7'b0110000, 1'b1});
    tab.push_back('{16'h1234, 4'hF, 4'h0, 2, 4'b1011, 7'b0100100, 1'b1});
    tab.push_back('{16'h1234, 4'hF, 4'h0, 3, 4'b0111, 7'b1111001, 1'b1});
    tab.push_back('{16'hABCD, 4'hF, 4'h0, 0, 4'b1110, 7'b0100001, 1'b1});
    tab.push_back('{16'hABCD, 4'hF, 4'h0, 1, 4'b1101, 7'b1000110, 1'b1});
    tab.push_back('{16'hABCD, 4'hF, 4'h0, 2, 4'b1011, 7'b0000011, 1'b1});
    tab.push_back('{16'hABCD, 4'hF, 4'h0, 3, 4'b0111, 7'b0001000, 1'b1});
    tab.push_back('{16'h5678, 4'b0101, 4'b0001, 0, 4'b1110, 7'b0000000, 1'b0});
    tab.push_back('{16'h5678, 4'b0101, 4'b0001, 1, 4'b1111, 7'h7F,      1'b1});
    tab.push_back('{16'h5678, 4'b0101, 4'b0001, 2, 4'b1011, 7'b0000010, 1'b1});
    tab.push_back('{16'h5678, 4'b0101, 4'b0001, 3, 4'b1111, 7'h7F,      1'b1});
    tab.push_back('{16'h9EF0, 4'hF, 4'hF, 0, 4'b1110, 7'b1000000, 1'b0});
    tab.push_back('{16'h9EF0, 4'hF, 4'hF, 1, 4'b1101, 7'b0001110, 1'b0});
    tab.push_back('{16'h9EF0, 4'hF, 4'hF, 2, 4'b1011, 7'b0000110, 1'b0});
    tab.push_back('{16'h9EF0, 4'hF, 4'hF, 3, 4'b0111, 7'b0010000, 1'b0});
    tab.push_back('{16'h0007, 4'hF, 4'b1110, 0, 4'b1110, 7'b1111000, 1'b1});
`ifdef SEG7_ZERO_BLANK_EN
    tab.push_back('{16'h0007, 4'hF, 4'b1110, 1, 4'b1111, 7'h7F, 1'b1});
    tab.push_back('{16'h0007, 4'hF, 4'b1110, 2, 4'b1111, 7'h7F, 1'b1});
    tab.push_back('{16'h0007, 4'hF, 4'b1110, 3, 4'b1111, 7'h7F, 1'b1});
    tab.push_back('{16'h0A05, 4'hF, 4'h0, 3, 4'b1111, 7'h7F, 1'b1});
`else
    tab.push_back('{16'h0007, 4'hF, 4'b1110, 1, 4'b1101, 7'b1000000, 1'b0});
    tab.push_back('{16'h0007, 4'hF, 4'b1110, 2, 4'b1011, 7'b1000000, 1'b0});
    tab.push_back('{16'h0007, 4'hF, 4'b1110, 3, 4'b0111, 7'b1000000, 1'b0});
    tab.push_back('{16'h0A05, 4'hF, 4'h0, 3, 4'b0111, 7'b1000000, 1'b1});
`endif
    tab.push_back('{16'h0A05, 4'hF, 4'h0, 1, 4'b1101, 7'b1000000, 1'b1});

    // Reset state
    rst = 1'b1;
    step();
    checking = 1'b1;
    check("reset_div4", 32'({an4, sg4, dp4, fd4}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    check("reset_div1", 32'({an1, sg1, dp1, fd1}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    step();
    rst = 1'b0;

    // Table-driven decode / enable / dp / zero-blank checks
    for (int i = 0; i < tab.size(); i++) begin
      value    = tab[i].val;
      digit_en = tab[i].en;
      dp_in    = tab[i].dp;
      wait_frame();
      wait_slot(tab[i].slot);
      check($sformatf("table%0d_anode", i), 32'(an4), 32'(tab[i].an));
      check($sformatf("table%0d_segment", i), 32'(sg4), 32'(tab[i].sg));
      check($sformatf("table%0d_dp", i), 32'(dp4), 32'(tab[i].dpo));
    end

    // Mid-frame value change stays hidden until the next frame
    value = 16'h1234; digit_en = 4'hF; dp_in = 4'h0;
    wait_frame();
    wait_frame();
    step();
    step();
    value = 16'hABCD;
    wait_slot(1);
    check("midframe_slot1", 32'(sg4), 32'(7'b0110000));
    wait_slot(3);
    check("midframe_slot3", 32'(sg4), 32'(7'b1111001));
    wait_frame();
    check("next_frame_slot0", 32'(sg4), 32'(7'b0100001));

    // frameDone spacing
    wait_dut_fd(1'b0, cyc);
    wait_dut_fd(1'b0, cyc);
    check("frame_period_div4", 32'(cyc), 32'(16));
    wait_dut_fd(1'b1, cyc);
    wait_dut_fd(1'b1, cyc);
    check("frame_period_div1", 32'(cyc), 32'(4));

    // Asynchronous reset mid-slot, then recovery timing
    value = 16'h00C5;
    wait_frame();
    step();
    rst = 1'b1;
    #1;
    check("reset_async_div4", 32'({an4, sg4, dp4, fd4}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    check("reset_async_div1", 32'({an1, sg1, dp1, fd1}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    step();
    step();
    rst = 1'b0;
    step();
    step();
    step();
    check("post_reset_dark", 32'(an4), 32'(4'hF));
    step();
    check("post_reset_digit0_an", 32'(an4), 32'(4'b1110));
    check("post_reset_digit0_seg", 32'(sg4), 32'(7'b0010010));

    // Randomized stimulus against the model
    for (c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      step();
    end

    // Final report
    @(posedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scanner.md
SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 The block SHALL have one parameter, REFRESH_DIV, default 50000, giving mainClock cycles per digit slot; legal values are 1 and above.
REQ-002 mainClock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 value  in  16  four hex nibbles; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-005 digitEnable  in  4  per-digit enable; bit n=0 SHALL keep digit n dark.
REQ-006 dpIn  in  4  per-digit decimal point request, active-high.
REQ-007 anode  out  4  digit select, active-low, one-hot-low or all-ones.
REQ-008 segment  out  7  {g,f,e,d,c,b,a}, active-low.
REQ-009 dpOut  out  1  decimal point, active-low.
REQ-010 frameDone  out  1  one-cycle pulse marking each new frame capture.

Function
REQ-011 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL assert in the cycle the count is REFRESH_DIV-1. With REFRESH_DIV=1, tick SHALL assert every cycle.
REQ-012 The 2-bit digit index SHALL advance by one on each tick, wrapping 3->0.
REQ-013 On a tick with index 3, shadow SHALL capture value, digitEnable and dpIn, and frameDone SHALL pulse in the following cycle.
REQ-014 The displayed frame SHALL never mix two captures; value changes mid-frame SHALL not be visible until the next 3->0 advance.
REQ-015 anode, segment and dpOut SHALL be registered and SHALL change only on the cycle after a tick, reflecting the new index and the shadow.
REQ-016 For an enabled slot n, anode SHALL be low in bit n only; segment SHALL be the hex decode of shadow nibble n; dpOut SHALL be ~shadow dp[n].
REQ-017 For a disabled slot n, anode SHALL be 4'b1111, segment 7'h7F and dpOut 1; the index SHALL still advance.
REQ-018 The hex decode SHALL map 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000, A->0001000, b->0000011, C->1000110, d->0100001, E->0000110, F->0001110.
REQ-019 Worst-case latency from a value change to its display SHALL be 4*REFRESH_DIV+1 cycles.

Reset
REQ-020 While reset is asserted, prescaler SHALL be 0, index 3, shadow 0, anode 4'b1111, segment 7'h7F, dpOut 1 and frameDone 0.
REQ-021 A reset asserted mid-frame SHALL blank outputs immediately without waiting for a clock edge.
REQ-022 The first tick after reset release SHALL capture a frame and display digit 0.

Configuration
REQ-023 With SEG7_ZERO_BLANK_EN defined, digit n (n=3..1) SHALL be dark when shadow nibbles n..3 are all zero; digit 0 SHALL never be zero-blanked.
REQ-024 Zero-blanking SHALL suppress the digit's decimal point too.
REQ-025 Without SEG7_ZERO_BLANK_EN, every enabled digit SHALL display, including leading zeros.

Structure
REQ-026 A shared package, seg7_pkg, SHALL hold the hex-to-segment table, SEG_BLANK (7'h7F) and ANODE_OFF (4'b1111).
REQ-027 The hex decode SHALL be a purely combinational sub-module, seg7_hex_decoder, instantiated once on the selected nibble.

Verification (REFRESH_DIV=4)
REQ-028 Reset, then value=16'h1234 with all digits enabled -> the sequence anode 1110/1101/1011/0111 with segments 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1), each held 4 cycles; frameDone pulses every 16 cycles.
REQ-029 Change value to 16'hABCD two cycles after a capture -> the remainder of the frame still shows 1234, and the next frame shows d, C, b, A.
REQ-030 Set digitEnable=4'b0101 and dpIn=4'b0001 -> slots 1 and 3 drive anode 1111 and segment 7F, and dpOut=0 only in slot 0.
REQ-031 Assert reset mid-slot -> anode=1111 and segment=7F immediately; after release, digit 0 appears 4 cycles later.
REQ-032 Apply value=16'h0007 with and without SEG7_ZERO_BLANK_EN -> with the macro, digits 3..1 are dark; without it, they show 1000000.
REQ-033 Rerun with REFRESH_DIV=1 and value=16'hF00F -> the digit advances every cycle, and frameDone pulses every 4 cycles.
